// File: rtl/hilo_pkg.sv
// Shared types and defaults for the HI/LO controller that launches the
// Booth multiplier and the sequential divider.
package hilo_pkg;

    localparam int HILO_W       = 32;
    localparam int HILO_TIMEOUT = 40;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        WRITE  = 2'd3
    } hilo_state_e;

    typedef enum logic [0:0] {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } hilo_op_e;

    // Only the unit that was launched is allowed to complete the operation.
    function automatic logic sel_end(input hilo_op_e op, input logic mult_end, input logic div_end);
        logic res;
        if (op == OP_MULT) begin
            res = mult_end;
        end else begin
            res = div_end;
        end
        return res;
    endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// HI/LO architectural registers plus the launch/wait/commit sequencer for
// the multiplier and divider, with mthi/mtlo writes and a watchdog.
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int TIMEOUT = HILO_TIMEOUT,
    parameter int W       = HILO_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_mult,
    input  logic         start_div,
    input  logic         mt_hi,
    input  logic         mt_lo,
    input  logic [W-1:0] rs,
    input  logic [W-1:0] rt,
    input  logic [W-1:0] wdata,
    output logic         mult_go,
    input  logic         mult_end,
    input  logic [W-1:0] mult_high,
    input  logic [W-1:0] mult_low,
    output logic         div_go,
    input  logic         div_end,
    input  logic [W-1:0] div_high,
    input  logic [W-1:0] div_low,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic         timeout
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    hilo_state_e     state_r;
    hilo_state_e     state_s;
    hilo_op_e        op_r;
    logic [WD_W-1:0] wd_r;
    logic [W-1:0]    op_a_r;
    logic [W-1:0]    op_b_r;
    logic [W-1:0]    hi_r;
    logic [W-1:0]    lo_r;
    logic            mult_go_r;
    logic            div_go_r;
    logic            busy_r;
    logic            done_r;
    logic            div_zero_r;
    logic            timeout_r;

    logic            idle_s;
    logic            acc_mult_s;
    logic            acc_div_s;
    logic            rej_div_s;
    logic            end_s;
    logic            expire_s;
    logic [W-1:0]    res_high_s;
    logic [W-1:0]    res_low_s;

    // Request decode: mult wins over div, div by zero is rejected in IDLE.
    always_comb begin
        idle_s     = (state_r == IDLE);
        acc_mult_s = idle_s & start_mult;
        acc_div_s  = idle_s & ~start_mult & start_div & (rt != {W{1'b0}});
        rej_div_s  = idle_s & ~start_mult & start_div & (rt == {W{1'b0}});
        end_s      = (state_r == WAIT) & sel_end(op_r, mult_end, div_end);
        expire_s   = (state_r == WAIT) & ~end_s & (wd_r == WD_LAST);
        if (op_r == OP_MULT) begin
            res_high_s = mult_high;
            res_low_s  = mult_low;
        end else begin
            res_high_s = div_high;
            res_low_s  = div_low;
        end
    end

    // Next-state logic for the launch/wait/commit sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (acc_mult_s | acc_div_s) begin
                    state_s = LAUNCH;
                end else begin
                    state_s = IDLE;
                end
            end
            LAUNCH: state_s = WAIT;
            WAIT: begin
                if (end_s) begin
                    state_s = WRITE;
                end else if (expire_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            WRITE:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, op and watchdog registers; LAUNCH clears the watchdog so stale
    // end levels from the previous op are never counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            op_r    <= OP_MULT;
            wd_r    <= {WD_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (acc_mult_s) begin
                op_r <= OP_MULT;
            end else if (acc_div_s) begin
                op_r <= OP_DIV;
            end else begin
                op_r <= op_r;
            end
            if (state_r == LAUNCH) begin
                wd_r <= {WD_W{1'b0}};
            end else if ((state_r == WAIT) && !end_s) begin
                wd_r <= wd_r + {{(WD_W-1){1'b0}}, 1'b1};
            end else begin
                wd_r <= wd_r;
            end
        end
    end

    // Operand latch and HI/LO: mt_* writes only in IDLE, results only on end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a_r <= {W{1'b0}};
            op_b_r <= {W{1'b0}};
            hi_r   <= {W{1'b0}};
            lo_r   <= {W{1'b0}};
        end else begin
            if (acc_mult_s | acc_div_s) begin
                op_a_r <= rs;
                op_b_r <= rt;
            end else begin
                op_a_r <= op_a_r;
                op_b_r <= op_b_r;
            end
            if (end_s) begin
                hi_r <= res_high_s;
                lo_r <= res_low_s;
            end else if (idle_s) begin
                hi_r <= mt_hi ? wdata : hi_r;
                lo_r <= mt_lo ? wdata : lo_r;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end
    end

    // Registered handshake pulses towards the units and the control unit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mult_go_r  <= 1'b0;
            div_go_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            mult_go_r  <= acc_mult_s;
            div_go_r   <= acc_div_s;
            busy_r     <= (state_s == LAUNCH) | (state_s == WAIT);
            done_r     <= end_s;
            div_zero_r <= rej_div_s;
            timeout_r  <= expire_s;
        end
    end

    assign mult_go  = mult_go_r;
    assign div_go   = div_go_r;
    assign op_a     = op_a_r;
    assign op_b     = op_b_r;
    assign hi       = hi_r;
    assign lo       = lo_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign timeout  = timeout_r;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl with behavioural multiplier/divider
// models and a transaction-level HI/LO reference.
module tb_hilo_ctrl;
    import hilo_pkg::*;

    localparam int W   = 32;
    localparam int TMO = 40;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_mult, start_div, mt_hi, mt_lo;
    logic [W-1:0] rs, rt, wdata;
    logic         mult_go, div_go;
    logic         mult_end = 1'b0;
    logic         div_end  = 1'b0;
    logic [W-1:0] mult_high = '0, mult_low = '0, div_high = '0, div_low = '0;
    logic [W-1:0] op_a, op_b, hi, lo;
    logic         busy, done, div_zero, timeout;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] hi_ref = '0;
    logic [W-1:0] lo_ref = '0;

    int  mult_lat = 32;
    int  div_lat  = 33;
    bit  mult_stuck = 1'b0;
    int  m_cnt = 0;
    int  d_cnt = 0;
    logic [63:0] m_res = '0;
    logic [63:0] d_res = '0;

    always #5 clk = ~clk;

    hilo_ctrl #(.TIMEOUT(TMO), .W(W)) dut (
        .clk(clk), .reset(reset),
        .start_mult(start_mult), .start_div(start_div),
        .mt_hi(mt_hi), .mt_lo(mt_lo),
        .rs(rs), .rt(rt), .wdata(wdata),
        .mult_go(mult_go), .mult_end(mult_end),
        .mult_high(mult_high), .mult_low(mult_low),
        .div_go(div_go), .div_end(div_end),
        .div_high(div_high), .div_low(div_low),
        .op_a(op_a), .op_b(op_b), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .div_zero(div_zero), .timeout(timeout)
    );

    // Multiplier model: end rises mult_lat edges after go is seen, then holds.
    always @(posedge clk) begin
        if (mult_go) begin
            mult_end <= 1'b0;
            m_cnt    <= mult_lat;
            m_res    <= $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !mult_stuck) begin
                mult_end  <= 1'b1;
                mult_high <= m_res[63:32];
                mult_low  <= m_res[31:0];
            end
        end
    end

    // Divider model: quotient on low, remainder on high.
    always @(posedge clk) begin
        if (div_go) begin
            div_end <= 1'b0;
            d_cnt   <= div_lat;
            if (op_b != '0) d_res <= {$signed(op_a) % $signed(op_b), $signed(op_a) / $signed(op_b)};
            else            d_res <= '1;
        end else if (d_cnt > 0) begin
            d_cnt <= d_cnt - 1;
            if (d_cnt == 1) begin
                div_end  <= 1'b1;
                div_high <= d_res[63:32];
                div_low  <= d_res[31:0];
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mt_write(input bit h, input bit l, input logic [W-1:0] d);
        mt_hi = h; mt_lo = l; wdata = d;
        tick();
        mt_hi = 1'b0; mt_lo = 1'b0;
        if (h) hi_ref = d;
        if (l) lo_ref = d;
        check_val("mt_hi", hi, hi_ref);
        check_val("mt_lo", lo, lo_ref);
    endtask

    task automatic div_by_zero(input logic [W-1:0] a);
        rs = a; rt = '0; start_div = 1'b1;
        tick();
        start_div = 1'b0;
        check_val("dz_pulse", div_zero, 1);
        check_val("dz_no_go", div_go, 0);
        check_val("dz_busy", busy, 0);
        tick();
        check_val("dz_once", div_zero, 0);
        check_val("dz_no_go2", div_go, 0);
        check_val("dz_hi", hi, hi_ref);
        check_val("dz_lo", lo, lo_ref);
    endtask

    task automatic run_op(input bit is_mult, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int lat, input bit both, input bit poke);
        longint p;
        int n;
        int go_cnt;
        bit seen;
        if (is_mult) begin
            p = longint'($signed(a)) * longint'($signed(b));
            mult_lat = lat;
        end else begin
            p = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            div_lat = lat;
        end
        rs = a; rt = b;
        start_mult = is_mult | both;
        start_div  = ~is_mult | both;
        tick();
        start_mult = 1'b0; start_div = 1'b0;
        check_val(is_mult ? "mult_go" : "div_go", is_mult ? mult_go : div_go, 1);
        check_val("other_go", is_mult ? div_go : mult_go, 0);
        check_val("busy_start", busy, 1);
        check_val("op_a", op_a, a);
        check_val("op_b", op_b, b);
        n = 0; go_cnt = 0; seen = 1'b0;
        while (n < 100 && !seen) begin
            tick();
            n++;
            if (mult_go || div_go) go_cnt++;
            if (done) seen = 1'b1;
            else if (n == lat) check_val("busy_mid", busy, 1);
            if (poke && n == 5) begin
                start_mult = 1'b1; mt_lo = 1'b1; mt_hi = 1'b1; wdata = 32'hDEAD_BEEF;
            end else begin
                start_mult = 1'b0; mt_lo = 1'b0; mt_hi = 1'b0;
            end
        end
        hi_ref = p[63:32];
        lo_ref = p[31:0];
        check_val("done_latency", 64'(n), 64'(lat + 2));
        check_val("go_single", 64'(go_cnt), 0);
        check_val("res_hi", hi, hi_ref);
        check_val("res_lo", lo, lo_ref);
        check_val("busy_done", busy, 0);
        tick();
        check_val("done_once", done, 0);
    endtask

    initial begin
        logic [W-1:0] a, b;
        int n;
        int dcnt;
        reset = 1'b1;
        start_mult = 1'b0; start_div = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
        rs = '0; rt = '0; wdata = '0;
        #2 reset = 1'b0;
        tick(); tick();
        check_val("rst_hi", hi, 0);
        check_val("rst_lo", lo, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_go", {mult_go, div_go}, 0);
        check_val("rst_op", {op_a, op_b}, 0);
        reset = 1'b1;
        tick();

        mt_write(1'b1, 1'b0, 32'h1234);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFD, 32, 1'b0, 1'b0);
        check_val("mult_hi_const", hi, 64'hFFFF_FFFF);
        check_val("mult_lo_const", lo, 64'hFFFF_FFEB);
        run_op(1'b0, 32'd100, 32'd7, 33, 1'b0, 1'b0);
        check_val("div_q_const", lo, 64'd14);
        check_val("div_r_const", hi, 64'd2);
        mt_write(1'b1, 1'b1, 32'hA);
        mt_write(1'b0, 1'b1, 32'hB);
        div_by_zero(32'd5);
        run_op(1'b1, 32'h0001_0003, 32'h0000_0100, 32, 1'b1, 1'b0);
        run_op(1'b1, 32'hFFFF_FF00, 32'h0000_0011, 32, 1'b0, 1'b1);

        // Watchdog expiry with a multiplier that never finishes.
        mult_stuck = 1'b1;
        rs = 32'd3; rt = 32'd4; start_mult = 1'b1;
        tick();
        start_mult = 1'b0;
        n = 0; dcnt = 0;
        while (n < 100 && !timeout) begin
            tick(); n++;
            if (done) dcnt++;
        end
        check_val("timeout_latency", 64'(n), 64'(TMO + 1));
        check_val("timeout_hi", hi, hi_ref);
        check_val("timeout_lo", lo, lo_ref);
        check_val("timeout_busy", busy, 0);
        check_val("timeout_no_done", 64'(dcnt), 0);
        tick();
        check_val("timeout_once", timeout, 0);
        mult_stuck = 1'b0;
        run_op(1'b1, 32'd12, 32'd13, 32, 1'b0, 1'b0);

        // Reset while waiting on the multiplier.
        rs = 32'd9; rt = 32'd9; start_mult = 1'b1;
        tick();
        start_mult = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        #1;
        check_val("mrst_hi", hi, 0);
        check_val("mrst_lo", lo, 0);
        check_val("mrst_busy", busy, 0);
        hi_ref = '0; lo_ref = '0;
        tick(); tick();
        reset = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) dcnt++;
        end
        check_val("mrst_end_seen", mult_end, 1);
        check_val("mrst_no_done", 64'(dcnt), 0);
        check_val("mrst_hi_after", hi, 0);
        check_val("mrst_lo_after", lo, 0);

        // Randomized mix of operations against the reference.
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 3))
                0: run_op(1'b1, $urandom, $urandom, 32, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                1: begin
                    a = 32'($urandom_range(0, 200000)) - 32'd100000;
                    b = 32'($urandom_range(1, 2000));
                    if ($urandom_range(0, 1) == 1) b = -b;
                    run_op(1'b0, a, b, $urandom_range(2, 35), 1'b0, 1'b0);
                end
                2: div_by_zero($urandom);
                default: mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
